mem_region_router: RTL

- Parametrised address-region router between the 3-stage core's data-side load/store port and NUM_REGIONS memory/IO targets (cache, BIOS, ISR memory, IO).
- Decodes the address tag field and drives one-hot request strobes.
- Holds the request stable across stall and registers the read-return select for the 1-cycle-latency targets.
- Flags and counts illegal accesses: unmapped addresses and writes to read-only regions.

---
 rtl/mem_map_pkg.sv | 10 +
 rtl/region_decoder.sv | 18 +
 rtl/mem_region_router.sv | 89 ++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: default region map and region indices for the data-side router
package mem_map_pkg;
  localparam int TAG_W = 4;
  localparam logic [15:0] REGION_TAGS = 16'h8C41;
  localparam logic [3:0] RO_MASK = 4'b0010;
  localparam int RGN_CACHE = 0;
  localparam int RGN_BIOS = 1;
  localparam int RGN_ISR = 2;
  localparam int RGN_IO = 3;
endpackage

// File: rtl/region_decoder.sv
// region_decoder: priority tag match giving a one-hot region select and a miss flag
module region_decoder #(
  parameter int NUM_REGIONS = 4,
  parameter int TAG_W = mem_map_pkg::TAG_W,
  parameter logic [NUM_REGIONS*TAG_W-1:0] REGION_TAGS = mem_map_pkg::REGION_TAGS
) (
  input  logic [TAG_W-1:0]       tag,
  output logic [NUM_REGIONS-1:0] sel,
  output logic                   miss
);
  logic [NUM_REGIONS-1:0] hit;
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) hit[i] = tag == REGION_TAGS[TAG_W*i +: TAG_W];
    // isolate the lowest set bit so duplicate tags resolve to the lowest index
    sel = hit & (~hit + NUM_REGIONS'(1));
    miss = sel == '0;
  end
endmodule

// File: rtl/mem_region_router.sv
// mem_region_router: routes the core's load/store port to tag-mapped targets, holding reads across stall
module mem_region_router
  import mem_map_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NUM_REGIONS = 4,
  parameter int TAG_W = mem_map_pkg::TAG_W,
  parameter logic [NUM_REGIONS*TAG_W-1:0] REGION_TAGS = mem_map_pkg::REGION_TAGS,
  parameter logic [NUM_REGIONS-1:0] RO_MASK = mem_map_pkg::RO_MASK,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [AW-1:0]                cpu_addr,
  input  logic                         cpu_re,
  input  logic [DW/8-1:0]              cpu_we,
  input  logic [DW-1:0]                cpu_din,
  output logic [DW-1:0]                cpu_dout,
  output logic                         cpu_err,
  output logic [AW-1:0]                rgn_addr,
  output logic [DW-1:0]                rgn_din,
  output logic [NUM_REGIONS-1:0]       rgn_re,
  output logic [NUM_REGIONS*DW/8-1:0]  rgn_we,
  input  logic [NUM_REGIONS*DW-1:0]    rgn_dout,
  output logic [CNT_W-1:0]             err_count
);
  localparam int BW = DW / 8;
  logic [NUM_REGIONS-1:0] sel, sel_q, sel_d, rsel_q, rsel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic re_q, re_d, err_q, err_d, miss, wr, illegal;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  region_decoder #(
    .NUM_REGIONS(NUM_REGIONS),
    .TAG_W(TAG_W),
    .REGION_TAGS(REGION_TAGS)
  ) u_dec (
    .tag(cpu_addr[AW-1:AW-TAG_W]),
    .sel(sel),
    .miss(miss)
  );

  always_comb begin
    wr = |cpu_we;
    illegal = !stall && (cpu_re || wr) && (miss || (wr && |(sel & RO_MASK)));
    addr_d = stall ? addr_q : cpu_addr;
    re_d = stall ? re_q : cpu_re;
    sel_d = stall ? sel_q : sel;
    rsel_d = stall ? rsel_q : (cpu_re ? sel : '0);
    err_d = illegal;
    cnt_d = (illegal && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      re_q <= 1'b0;
      sel_q <= '0;
      rsel_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      addr_q <= addr_d;
      re_q <= re_d;
      sel_q <= sel_d;
      rsel_q <= rsel_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // during stall the target sees the captured read; writes are never replayed
  assign rgn_addr = stall ? addr_q : cpu_addr;
  assign rgn_re = stall ? (re_q ? sel_q : '0) : (cpu_re ? sel : '0);
  assign rgn_din = cpu_din;
  assign cpu_err = err_q;
  assign err_count = cnt_q;

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_we
    assign rgn_we[BW*i +: BW] = (!stall && sel[i] && !RO_MASK[i]) ? cpu_we : '0;
  end

  always_comb begin
    cpu_dout = '0;
    for (int i = 0; i < NUM_REGIONS; i++) cpu_dout |= rsel_q[i] ? rgn_dout[DW*i +: DW] : '0;
  end
endmodule
